// File: rtl/conway_serial_host.sv
// rtl/conway_serial_host.sv - host driver that loads, steps and reads back the 8x8 serial Conway chip (optional: CONWAY_HOST_ALIVE_COUNT_EN)
module conway_serial_host #(
    parameter int DATA_SIZE = 64,
    parameter int GEN_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [DATA_SIZE-1:0] BOARD_IN,
    input  logic [GEN_WIDTH-1:0] GENERATIONS,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [DATA_SIZE-1:0] BOARD_OUT,
`ifdef CONWAY_HOST_ALIVE_COUNT_EN
    output logic [$clog2(DATA_SIZE+1)-1:0] ALIVE_COUNT,
`endif
    output logic                 CHIP_DATA_IN,
    output logic [1:0]           CHIP_MODE,
    input  logic                 CHIP_DATA_OUT
);

    localparam int CNT_W = $clog2(DATA_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_READ = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        READ,
        FINISH
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DATA_SIZE-1:0] tx;
    logic [DATA_SIZE-1:0] tx_next;
    logic [DATA_SIZE-1:0] rx;
    logic [DATA_SIZE-1:0] rx_next;
    logic [DATA_SIZE-1:0] rx_shift;
    logic [DATA_SIZE-1:0] board_next;
    logic [GEN_WIDTH-1:0] run_cnt;
    logic [GEN_WIDTH-1:0] run_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_next;
    logic [1:0]           mode_next;
    logic                 data_in_next;
    logic                 capture;

    // Next-state, shift registers and counters; outputs are decoded from the next state so they land registered
    always_comb begin
        state_next = state;
        tx_next    = tx;
        rx_next    = rx;
        run_next   = run_cnt;
        bit_next   = bit_cnt;
        board_next = BOARD_OUT;
        capture    = 1'b0;
        rx_shift   = {rx[DATA_SIZE-2:0], CHIP_DATA_OUT};

        case (state)
            IDLE: begin
                if (START) begin
                    state_next = LOAD;
                    tx_next    = BOARD_IN;
                    run_next   = GENERATIONS;
                    bit_next   = '0;
                end
            end
            LOAD: begin
                tx_next = tx << 1;
                if (bit_cnt == LAST_BIT) begin
                    bit_next   = '0;
                    state_next = (run_cnt != '0) ? RUN : READ;
                end else begin
                    bit_next = bit_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                // Exit on 1 so the full GEN_WIDTH range is usable without wrap
                if (run_cnt <= GEN_WIDTH'(1)) begin
                    run_next   = '0;
                    state_next = READ;
                end else begin
                    run_next = run_cnt - GEN_WIDTH'(1);
                end
            end
            READ: begin
                rx_next = rx_shift;
                if (bit_cnt == LAST_BIT) begin
                    bit_next   = '0;
                    state_next = FINISH;
                    board_next = rx_shift;
                    capture    = 1'b1;
                end else begin
                    bit_next = bit_cnt + CNT_W'(1);
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            LOAD:    mode_next = MODE_LOAD;
            RUN:     mode_next = MODE_RUN;
            READ:    mode_next = MODE_READ;
            default: mode_next = MODE_HOLD;
        endcase

        data_in_next = (state_next == LOAD) ? tx_next[DATA_SIZE-1] : 1'b0;
    end

    // State register and registered chip/requester outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            tx           <= '0;
            rx           <= '0;
            run_cnt      <= '0;
            bit_cnt      <= '0;
            BOARD_OUT    <= '0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            CHIP_MODE    <= MODE_HOLD;
            CHIP_DATA_IN <= 1'b0;
        end else begin
            state        <= state_next;
            tx           <= tx_next;
            rx           <= rx_next;
            run_cnt      <= run_next;
            bit_cnt      <= bit_next;
            BOARD_OUT    <= board_next;
            BUSY         <= (state_next != IDLE);
            DONE         <= (state_next == FINISH);
            CHIP_MODE    <= mode_next;
            CHIP_DATA_IN <= data_in_next;
        end
    end

`ifdef CONWAY_HOST_ALIVE_COUNT_EN
    logic [CNT_W-1:0] alive_calc;

    // Population count of the board as it completes on the last read edge
    always_comb begin
        alive_calc = '0;
        for (int i = 0; i < DATA_SIZE; i++) begin
            alive_calc = alive_calc + CNT_W'(rx_shift[i]);
        end
    end

    // Alive count is captured together with BOARD_OUT
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ALIVE_COUNT <= '0;
        end else if (capture) begin
            ALIVE_COUNT <= alive_calc;
        end
    end
`endif

endmodule

// File: tb/tb_conway_serial_host.sv
// tb/tb_conway_serial_host.sv - directed bench for conway_serial_host with a behavioural chip model
module tb_conway_serial_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] board_in;
    logic [15:0] generations;
    logic        busy;
    logic        done;
    logic [63:0] board_out;
    logic        chip_data_in;
    logic [1:0]  chip_mode;
    logic        chip_data_out;
`ifdef CONWAY_HOST_ALIVE_COUNT_EN
    logic [6:0]  alive_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] ECHO_B  = 64'hA5C3_0F96_1234_8001;
    localparam logic [63:0] BLINK_H = 64'h0000_0038_0000_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_1010_1000_0000;
    localparam logic [63:0] BLOCK_B = 64'h0000_0018_1800_0000;

    conway_serial_host dut (
        .CLK          (clk),
        .RESET        (reset),
        .START        (start),
        .BOARD_IN     (board_in),
        .GENERATIONS  (generations),
        .BUSY         (busy),
        .DONE         (done),
        .BOARD_OUT    (board_out),
`ifdef CONWAY_HOST_ALIVE_COUNT_EN
        .ALIVE_COUNT  (alive_count),
`endif
        .CHIP_DATA_IN (chip_data_in),
        .CHIP_MODE    (chip_mode),
        .CHIP_DATA_OUT(chip_data_out)
    );

    always #5 clk = ~clk;

    // Chip model: one generation of Conway life with dead borders, bit = 63 - (row*8 + col)
    function automatic logic [63:0] life_step(input logic [63:0] b);
        logic [63:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                            (c + dc) >= 0 && (c + dc) < 8) begin
                            cnt += int'(b[63 - ((r + dr) * 8 + c + dc)]);
                        end
                    end
                end
                n[63 - (r * 8 + c)] = (cnt == 3) || (cnt == 2 && b[63 - (r * 8 + c)]);
            end
        end
        return n;
    endfunction

    logic [63:0] chip_mem = '0;
    assign chip_data_out = chip_mem[63];

    // Chip model: load shifts DATA_IN in, run steps, output rotates so DATA_OUT walks MSB first
    always @(posedge clk) begin
        case (chip_mode)
            2'b00:   chip_mem <= {chip_mem[62:0], chip_data_in};
            2'b01:   chip_mem <= life_step(chip_mem);
            2'b10:   chip_mem <= {chip_mem[62:0], chip_mem[63]};
            default: chip_mem <= chip_mem;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full operation; poke pulses START at k+10 and during FINISH to prove they are ignored
    task automatic run_op(input string tag, input logic [63:0] b, input logic [15:0] g,
                          input logic [63:0] exp_b, input bit poke);
        int n00, n01, n10, n11, nbusy, ndone, lat, busy_after;
        bit finished;
        logic [63:0] seen;
        n00 = 0; n01 = 0; n10 = 0; n11 = 0; nbusy = 0; ndone = 0; lat = 0; busy_after = 0;
        finished = 1'b0;
        seen = '0;
        @(negedge clk);
        start = 1'b1;
        board_in = b;
        generations = g;
        @(posedge clk);
        #1;
        start = 1'b0;
        board_in = ~b;
        generations = 16'hFFFF;
        for (int i = 0; i < 70000 && !finished; i++) begin
            @(negedge clk);
            start = 1'b0;
            case (chip_mode)
                2'b00:   n00++;
                2'b01:   n01++;
                2'b10:   n10++;
                default: n11++;
            endcase
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                lat = i + 1;
                seen = board_out;
                if (poke) start = 1'b1;
            end
            if (poke && i == 9) begin
                start = 1'b1;
                board_in = 64'hFFFF_FFFF_FFFF_FFFF;
                generations = 16'd3;
            end
            if (!busy) finished = 1'b1;
        end
        check({tag, "_finished"}, 64'(finished), 64'd1);
        check({tag, "_done_count"}, 64'(ndone), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(129 + int'(g)));
        check({tag, "_board"}, seen, exp_b);
        check({tag, "_busy_cycles"}, 64'(nbusy), 64'(129 + int'(g)));
        check({tag, "_mode00"}, 64'(n00), 64'd64);
        check({tag, "_mode01"}, 64'(n01), 64'(g));
        check({tag, "_mode10"}, 64'(n10), 64'd64);
        check({tag, "_mode11"}, 64'(n11), 64'd2);
        if (poke) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (busy || done) busy_after++;
            end
            check({tag, "_ignored_start"}, 64'(busy_after), 64'd0);
            check({tag, "_board_hold"}, board_out, exp_b);
        end
    endtask

    initial begin
        int saw_done;
        reset = 1'b1;
        start = 1'b0;
        board_in = '0;
        generations = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mode", 64'(chip_mode), 64'h3);
        check("rst_data_in", 64'(chip_data_in), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_board", board_out, 64'd0);
`ifdef CONWAY_HOST_ALIVE_COUNT_EN
        check("rst_alive", 64'(alive_count), 64'd0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_op("echo", ECHO_B, 16'd0, ECHO_B, 1'b0);
        run_op("blink_g1", BLINK_H, 16'd1, BLINK_V, 1'b0);
`ifdef CONWAY_HOST_ALIVE_COUNT_EN
        check("alive_blink", 64'(alive_count), 64'd3);
`endif
        run_op("blink_g2", BLINK_H, 16'd2, BLINK_H, 1'b0);
        run_op("block_g5", BLOCK_B, 16'd5, BLOCK_B, 1'b0);
        run_op("poke", BLINK_H, 16'd1, BLINK_V, 1'b1);

        // Reset one cycle in the middle of RUN
        saw_done = 0;
        @(negedge clk);
        start = 1'b1;
        board_in = BLINK_H;
        generations = 16'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) saw_done++;
            if (i == 79) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        if (done) saw_done++;
        check("midrst_mode", 64'(chip_mode), 64'h3);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_board", board_out, 64'd0);
        check("midrst_no_done", 64'(saw_done), 64'd0);
`ifdef CONWAY_HOST_ALIVE_COUNT_EN
        check("midrst_alive", 64'(alive_count), 64'd0);
`endif
        run_op("after_rst", BLINK_H, 16'd2, BLINK_H, 1'b0);

        run_op("ones", 64'hFFFF_FFFF_FFFF_FFFF, 16'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
`ifdef CONWAY_HOST_ALIVE_COUNT_EN
        check("alive_ones", 64'(alive_count), 64'd64);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conway_serial_host.md
Name: conway_serial_host

Overview:
- Host-side driver for the 8x8 serial Conway chip. It is the opposite end of that chip's DATA_IN/DATA_OUT/MODE interface.
- Accepts a parallel 64-bit board and a generation count from a local requester.
- Serially loads the board into the chip, steps it the requested number of generations, then serially reads the result back into a parallel register.
- Used in FPGA test harnesses and board-level bring-up alongside the chip. Chip and host share CLK.

Parameters:
- DATA_SIZE, 64, board bits per transfer (grid width x height). The host always loads and reads exactly DATA_SIZE bits per operation.
- GEN_WIDTH, 16, width of the generation count.

Ports:
- CLK  input  1  system clock, shared with the chip
- RESET  input  1  synchronous, active-high reset
- START  input  1  request strobe, sampled only in IDLE
- BOARD_IN  input  DATA_SIZE  board to load, latched when START is accepted
- GENERATIONS  input  GEN_WIDTH  run-mode cycles to apply, latched when START is accepted
- BUSY  output  1  high in every state except IDLE
- DONE  output  1  single-cycle pulse when BOARD_OUT updates
- BOARD_OUT  output  DATA_SIZE  last board read back from the chip
- CHIP_DATA_IN  output  1  drives the chip's DATA_IN
- CHIP_MODE  output  2  drives the chip's MODE (00 load, 01 run, 10 output, 11 hold)
- CHIP_DATA_OUT  input  1  from the chip's DATA_OUT

Behaviour:
- Reset (one clock; synchronous, active-high):
  - state=IDLE, CHIP_MODE=11, CHIP_DATA_IN=0, BUSY=0, DONE=0, BOARD_OUT=0, all counters 0.
  - Reset mid-operation aborts immediately, with no partial BOARD_OUT update. Chip contents are then undefined to the host.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, READ, FINISH.
- IDLE:
  - CHIP_MODE=11.
  - START=1 at edge k latches BOARD_IN into the TX shift register and GENERATIONS into the run counter, then goes to LOAD.
  - START outside IDLE is ignored; no queueing.
- LOAD: cycles k+1..k+64.
  - CHIP_MODE=00; CHIP_DATA_IN = TX register MSB.
  - The TX register shifts left each cycle, so BOARD_IN[63] is sent first and BOARD_IN[0] last.
  - A 7-bit bit counter runs 0..63. At count 63, go to RUN if the latched GENERATIONS != 0, else go to READ.
- RUN: exactly G cycles, where G is the latched GENERATIONS.
  - CHIP_MODE=01; CHIP_DATA_IN=0.
  - The run counter decrements each cycle. Leave RUN when it reaches 1.
  - G=0 skips RUN entirely. G=2^GEN_WIDTH-1 must not wrap.
- READ: 64 cycles.
  - CHIP_MODE=10.
  - At each rising edge in READ, CHIP_DATA_OUT shifts into the RX register LSB, so the first sample ends at bit 63.
  - After 64 samples, go to FINISH.
- FINISH: one cycle.
  - BOARD_OUT <= RX register; DONE=1; CHIP_MODE=11.
  - Next state is IDLE. START in this cycle is ignored.
- Latency: DONE is asserted in cycle k+129+G after START is accepted at edge k.
  - BOARD_OUT is valid from that cycle and holds until the next FINISH or RESET.
- BUSY=1 from cycle k+1 through the FINISH cycle inclusive. BUSY=0 in the cycle after DONE, when a new START is accepted.
- Chip protocol invariant: output mode is always exactly 64 consecutive cycles. The host never leaves the chip in 10 for any other count.
- A MODE change takes effect at the chip on the same edge the host registers it; no extra settle cycles.

Optional Feature:
- Macro: CONWAY_HOST_ALIVE_COUNT_EN.
- Defined:
  - Adds output ALIVE_COUNT (width 7), the population count of the RX register.
  - Registered in FINISH alongside BOARD_OUT; reset value 0.
  - Range 0..64, no saturation needed.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Bench uses a behavioural chip model (64-bit shift memory plus reference Conway step, dead borders) on CHIP_* ports.
- Echo: BOARD_IN=64'hA5C3_0F96_1234_8001, GENERATIONS=0 -> DONE at k+129; BOARD_OUT=64'hA5C3_0F96_1234_8001; CHIP_MODE sequence 00x64, 10x64, 11.
- Blinker: horizontal row 3, cols 2..4 = 64'h0000_0038_0000_0000; G=1 -> vertical blinker 64'h0000_1010_1000_0000; G=2 -> original; DONE at k+130 and k+131 respectively.
- Still life: 2x2 block 64'h0000_0018_1800_0000, G=5 -> unchanged; BUSY high k+1..k+134, low at k+135.
- Busy rejection: START pulsed at k+10 and during FINISH -> ignored; exactly one DONE; BOARD_OUT reflects the first request only.
- Reset mid-RUN: G=100, RESET high one cycle at k+80 -> next cycle CHIP_MODE=11, BUSY=0, BOARD_OUT=0, no DONE; a subsequent START completes normally.
- With CONWAY_HOST_ALIVE_COUNT_EN: all-ones board, G=0 -> ALIVE_COUNT=64; blinker G=1 -> ALIVE_COUNT=3; after reset -> 0.
